// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b - bin, LSB first, behind a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-2:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;

  full_subtractor u_cell (
    .x  (r_ra[0]),
    .y  (r_rb[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  // Control FSM with datapath; result registers update only when entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= (WIDTH-1)'({w_d, r_acc} >> 1);
          if (r_cnt == CNT_LAST) begin
            r_diff  <= {w_d, r_acc};
            r_bout  <= w_bo;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Signed overflow: borrow into the MSB stage differs from borrow out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT && r_cnt == CNT_LAST) begin
      r_ovf <= r_br ^ w_bo;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
